// File: rtl/msg_word_packer.sv
// msg_word_packer: packs 32-bit message-memory words into 128-bit beats.
// A size descriptor frames each message. Beats go through an internal
// FIFO, and a registered hold output throttles the upstream read stage
// before that FIFO fills.
module msg_word_packer #(
    parameter int WORD_WIDTH  = 32,
    parameter int PACK_WIDTH  = 128,
    parameter int SIZE_WIDTH  = 11,
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  desc_valid,
    input  logic [SIZE_WIDTH-1:0] desc_size,
    output logic                  desc_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  hold,
    output logic [PACK_WIDTH-1:0] out_data,
    output logic [3:0]            out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] HOLD_THR = CNT_W'(FIFO_DEPTH - HOLD_MARGIN);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                state, state_next;
    logic [SIZE_WIDTH-1:0] words_left, words_left_next;
    logic [1:0]            lane, lane_next;
    logic [WORD_WIDTH-1:0] pack_lanes [4];

    // Beat assembled from the stored lanes plus the word arriving now
    logic [PACK_WIDTH-1:0] beat_data;
    logic [3:0]            beat_keep;
    logic                  beat_last;
    logic                  beat_push;
    logic                  word_in;
    logic                  stray_word;

    // FIFO storage and pointers
    logic [PACK_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [3:0]            keep_mem [FIFO_DEPTH];
    logic                  last_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  pop;
    logic                  fifo_write;
    logic                  overflow;

    assign desc_ready = (state == IDLE);
    assign word_in    = in_valid && (state == COLLECT);
    assign stray_word = in_valid && (state == IDLE);

    // Next-state logic for the framing FSM and the lane/word counters
    always_comb begin
        state_next      = state;
        words_left_next = words_left;
        lane_next       = lane;
        beat_push       = 1'b0;
        beat_last       = 1'b0;
        case (state)
            IDLE: begin
                if (desc_valid && desc_size != '0) begin
                    words_left_next = desc_size;
                    lane_next       = 2'd0;
                    state_next      = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    beat_last       = (words_left == SIZE_WIDTH'(1));
                    beat_push       = (lane == 2'd3) || beat_last;
                    words_left_next = words_left - SIZE_WIDTH'(1);
                    lane_next       = beat_push ? 2'd0 : lane + 2'd1;
                    if (beat_last)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane mux: stored lanes below the current lane, the live word at it, zero above
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) < lane)
                beat_data[k*WORD_WIDTH +: WORD_WIDTH] = pack_lanes[k];
            else if (2'(k) == lane)
                beat_data[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
        end
        case (lane)
            2'd0:    beat_keep = 4'b0001;
            2'd1:    beat_keep = 4'b0011;
            2'd2:    beat_keep = 4'b0111;
            default: beat_keep = 4'b1111;
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            words_left <= '0;
            lane       <= 2'd0;
        end else begin
            state      <= state_next;
            words_left <= words_left_next;
            lane       <= lane_next;
        end
    end

    // Pack register: data only, no reset needed since unused lanes are masked
    always_ff @(posedge clk) begin
        if (word_in)
            pack_lanes[lane] <= in_data;
    end

    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign fifo_write = beat_push && (!fifo_full || pop);
    assign overflow   = beat_push && fifo_full && !pop;

    // Beat FIFO storage
    always_ff @(posedge clk) begin
        if (fifo_write) begin
            data_mem[wr_ptr] <= beat_data;
            keep_mem[wr_ptr] <= beat_keep;
            last_mem[wr_ptr] <= beat_last;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_write)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (fifo_write && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !fifo_write)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // Head-of-FIFO view; forced to zero while empty so reset values are clean
    always_comb begin
        out_data = '0;
        out_keep = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = data_mem[rd_ptr];
            out_keep = keep_mem[rd_ptr];
            out_last = last_mem[rd_ptr];
        end
    end

    // Registered hold flag and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= 1'b0;
            err  <= 1'b0;
        end else begin
            hold <= (fifo_count >= HOLD_THR);
            if (stray_word || overflow)
                err <= 1'b1;
        end
    end

endmodule

// File: doc/msg_word_packer.md
# msg_word_packer

Downstream of the message-memory read stage: takes the 32-bit word stream read out of local message memory and packs it into 128-bit beats for the packetizer. Each message is framed by a size descriptor. Packed beats are buffered in an internal FIFO. The block drives `hold` back to the read stage so the FIFO never needs to overflow.

## Interface
- `WORD_WIDTH`, 32, width of one memory word
- `PACK_WIDTH`, 128, beat width; must equal 4*`WORD_WIDTH`
- `SIZE_WIDTH`, 11, message size field width, in words
- `FIFO_DEPTH`, 16, beat FIFO entries; power of two, at least 8
- `HOLD_MARGIN`, 4, free entries reserved when `hold` asserts

- `clk` in 1: clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `desc_valid` in 1: message descriptor valid
- `desc_size` in `SIZE_WIDTH`: message length in words
- `desc_ready` out 1: descriptor accepted when `desc_valid & desc_ready`
- `in_data` in `WORD_WIDTH`: word from the memory read stage
- `in_valid` in 1: `in_data` valid this cycle; no ready, always accepted
- `hold` out 1: request that upstream stop issuing reads
- `out_data` out `PACK_WIDTH`: packed beat; word lane k occupies bits [32k+31:32k]
- `out_keep` out 4: per-lane valid mask
- `out_last` out 1: final beat of the message
- `out_valid` out 1: beat available
- `out_ready` in 1: downstream accepts the beat when `out_valid & out_ready`
- `err` out 1: sticky error; cleared only by reset

## Operation
- The FSM has two states, IDLE and COLLECT.
  - `desc_ready` = (state == IDLE).
- **IDLE:**
  - A descriptor handshake with `desc_size` = 0 is consumed; the block produces no beats and stays in IDLE.
  - A descriptor with `desc_size` != 0 loads `words_left` = `desc_size`, sets `lane` = 0, and moves to COLLECT.
  - An `in_valid` word arriving in IDLE is dropped and sets `err`.
- **COLLECT:** each `in_valid` word is written into pack register lane `lane`, then `lane` increments (2-bit, wraps) and `words_left` decrements.
  - A beat is pushed when `lane` == 3 or `words_left` == 1.
  - `keep` = lanes 0..`lane` set, contiguous from lane 0.
  - `last` = (`words_left` == 1).
  - Unused lanes carry zero.
  - After the push, `lane` returns to 0.
  - After the final word, the state returns to IDLE in the same edge.
- **FIFO:** `FIFO_DEPTH` entries of {data, keep, last}, with synchronous write and read.
  - Read occurs on `out_valid & out_ready`.
  - Push and pop may occur in the same cycle; the count is then unchanged.
  - A push to a full FIFO with no simultaneous pop drops the beat and sets `err`. The packer state still advances.
- `hold` = (fifo_count >= `FIFO_DEPTH` - `HOLD_MARGIN`), registered.
  - Upstream may deliver up to `HOLD_MARGIN`*4 - 1 further words after `hold` rises without loss.
- A beat count is not 4-aligned: the number of beats equals ceil(size/4). Sizes are taken modulo 2^`SIZE_WIDTH`, so the maximum is 2047 words.

## Timing
- Reset values:
  - `desc_ready`=1
  - `hold`=0
  - `out_valid`=0
  - `out_data`=0
  - `out_keep`=0
  - `out_last`=0
  - `err`=0
  - FIFO empty
  - state IDLE
- Reset mid-message discards the pack register, FIFO contents and counters; the first post-reset descriptor starts cleanly.
- Descriptor accepted at edge t: the first word may be presented in cycle t+1.
- Latency:
  - The word completing a beat is valid in cycle t, and the beat is written at the end of cycle t.
  - If the FIFO was empty, `out_valid`=1 in cycle t+1 with the data on `out_data`.
- Beat throughput is limited to one per 4 input words. The FIFO sustains one pop per cycle.
- `hold` changes one cycle after the count crosses the threshold in either direction.
- `out_data`, `out_keep` and `out_last` remain stable while `out_valid & ~out_ready`.

## Test plan
- **Size 4:** descriptor size=4, words 0xA0..0xA3 back-to-back, `out_ready`=1 → one beat, data=0x000000A3_000000A2_000000A1_000000A0, keep=1111, last=1, `out_valid` one cycle after the 4th word.
- **Size 6:** descriptor size=6, words 1..6 → beat0 keep=1111 last=0; beat1 data lanes0/1=5,6, upper lanes 0, keep=0011, last=1; `desc_ready` high the cycle after word 6.
- **Size 0 and stray word:** descriptor size=0 → no beat, `desc_ready` stays 1; a following stray `in_valid` in IDLE → `err`=1 and no beat.
- **Backpressure:** size=64, `out_ready`=0 → `hold` rises when count reaches 12 (defaults), and FIFO holds all beats. Releasing `out_ready` drains 16 beats in order, and `hold` falls when count < 12.
- **Overflow:** size=80, `out_ready`=0, upstream ignores `hold` → beats 17..20 dropped and `err`=1. Drain yields exactly 16 beats.
- **Reset mid-message:** reset after word 2 of a size-8 message → outputs at reset values. A new size-4 message then produces one correct beat with last=1.
